// File: rtl/stack_ctrl_if.sv
// Request/acknowledge bundle between a requester and stack_ctrl.
// master drives requests; slave returns ack, err and the popped address.
interface stack_ctrl_if #(
    parameter int AW = 11
);
    logic          call_req;
    logic          ret_req;
    logic          irq_req;
    logic          reti_req;
    logic          err_clr;
    logic [AW-1:0] pc_in;
    logic          ack;
    logic          err;
    logic [AW-1:0] ret_addr;

    modport master (
        output call_req, ret_req, irq_req, reti_req, err_clr, pc_in,
        input  ack, err, ret_addr
    );

    modport slave (
        input  call_req, ret_req, irq_req, reti_req, err_clr, pc_in,
        output ack, err, ret_addr
    );
endinterface

// File: rtl/stack_ctrl.sv
// Call/return stack controller driving an external registered-read LIFO.
// Define STACK_CTRL_IRQ_EN to enable irq/reti handling and in_isr tracking.
module stack_ctrl #(
    parameter int AW        = 11,
    parameter int DEPTH_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    stack_ctrl_if.slave   bus,
    input  logic [AW-1:0] lifo_dout,
    output logic          lifo_wr_en,
    output logic          lifo_rd_en,
    output logic [AW-1:0] lifo_din,
    output logic [4:0]    depth,
    output logic          busy,
    output logic          overflow,
    output logic          underflow,
    output logic          in_isr
);
    typedef enum logic [2:0] {IDLE, PUSH, POP, CAP, REJ} state_t;

    localparam logic [4:0] DMAX = 5'(DEPTH_MAX);

    state_t        state, state_d;
    logic          go, push_sel;
    logic          op_push;
    logic [AW-1:0] ret_q;

`ifdef STACK_CTRL_IRQ_EN
    logic irq_sel, reti_sel;
    logic op_irq, op_reti;
`endif

    always_comb begin
        go       = 1'b0;
        push_sel = 1'b0;
`ifdef STACK_CTRL_IRQ_EN
        irq_sel  = 1'b0;
        reti_sel = 1'b0;
        if (bus.irq_req && !in_isr) begin
            go       = 1'b1;
            push_sel = 1'b1;
            irq_sel  = 1'b1;
        end else if (bus.reti_req && in_isr) begin
            go       = 1'b1;
            reti_sel = 1'b1;
        end else
`endif
        if (bus.call_req) begin
            go       = 1'b1;
            push_sel = 1'b1;
        end else if (bus.ret_req) begin
            go = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (go) begin
                    if (push_sel)
                        state_d = (depth < DMAX) ? PUSH : REJ;
                    else
                        state_d = (depth != 5'd0) ? POP : REJ;
                end
            end
            PUSH:    state_d = IDLE;
            POP:     state_d = CAP;
            CAP:     state_d = IDLE;
            REJ:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign lifo_wr_en   = (state == PUSH);
    assign lifo_rd_en   = (state == POP);
    assign bus.ack      = (state == PUSH) || (state == CAP) || (state == REJ);
    assign bus.err      = (state == REJ);
    assign busy         = (state != IDLE);
    // Forward LIFO data during CAP so ret_addr is valid on the ack cycle.
    assign bus.ret_addr = (state == CAP) ? lifo_dout : ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_push   <= 1'b0;
            lifo_din  <= '0;
            depth     <= 5'd0;
            ret_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && go) begin
                op_push <= push_sel;
                if (push_sel)
                    lifo_din <= bus.pc_in;
            end
            if (state == PUSH)
                depth <= depth + 5'd1;
            if (state == POP)
                depth <= depth - 5'd1;
            if (state == CAP)
                ret_q <= lifo_dout;
            overflow  <= (bus.err && op_push) ||
                         (overflow && !bus.err_clr);
            underflow <= (bus.err && !op_push) ||
                         (underflow && !bus.err_clr);
        end
    end

`ifdef STACK_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            in_isr  <= 1'b0;
            op_irq  <= 1'b0;
            op_reti <= 1'b0;
        end else begin
            if (state == IDLE && go) begin
                op_irq  <= irq_sel;
                op_reti <= reti_sel;
            end
            if (state == PUSH && op_irq)
                in_isr <= 1'b1;
            // A rejected reti still leaves interrupt context.
            if ((state == CAP || state == REJ) && op_reti)
                in_isr <= 1'b0;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{bus.irq_req, bus.reti_req};
    assign in_isr     = 1'b0;
`endif
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural LIFO.
// Irq scenarios depend on whether STACK_CTRL_IRQ_EN is defined.
module tb_stack_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] lifo_dout;
    logic        lifo_wr_en, lifo_rd_en;
    logic [10:0] lifo_din;
    logic [4:0]  depth;
    logic        busy, overflow, underflow, in_isr;

    int total = 0;
    int bad   = 0;

    stack_ctrl_if #(.AW(11)) bus ();

    stack_ctrl #(.AW(11), .DEPTH_MAX(15)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lifo_dout(lifo_dout), .lifo_wr_en(lifo_wr_en),
        .lifo_rd_en(lifo_rd_en), .lifo_din(lifo_din),
        .depth(depth), .busy(busy), .overflow(overflow),
        .underflow(underflow), .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    logic [10:0] mem [16];
    logic [4:0]  sp;
    logic [4:0]  spm1;
    logic        both_seen = 1'b0;
    assign spm1 = sp - 5'd1;

    always @(posedge clk) begin
        if (rst) begin
            sp        <= 5'd0;
            lifo_dout <= 11'd0;
        end else begin
            if (lifo_wr_en && sp < 5'd16) begin
                mem[sp[3:0]] <= lifo_din;
                sp <= sp + 5'd1;
            end
            if (lifo_rd_en && sp > 5'd0) begin
                lifo_dout <= mem[spm1[3:0]];
                sp <= spm1;
            end
        end
    end

    always @(negedge clk)
        if (lifo_wr_en && lifo_rd_en) both_seen = 1'b1;

    task automatic drop_reqs();
        bus.call_req = 1'b0;
        bus.ret_req  = 1'b0;
        bus.irq_req  = 1'b0;
        bus.reti_req = 1'b0;
    endtask

    task automatic apply_rst();
        @(negedge clk);
        rst = 1'b1;
        drop_reqs();
        bus.err_clr = 1'b0;
        bus.pc_in   = 11'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // kind: 0 call, 1 ret, 2 irq, 3 reti; cyc=0 means no ack within bound
    task automatic do_op(input int kind, input logic [10:0] pc,
                         input int bound, output int cyc,
                         output logic e, output logic wr,
                         output logic rd, output logic [10:0] ra,
                         output logic [10:0] din);
        cyc = 0; e = 1'b0; wr = 1'b0; rd = 1'b0;
        ra = 11'd0; din = 11'd0;
        bus.pc_in = pc;
        case (kind)
            0: bus.call_req = 1'b1;
            1: bus.ret_req  = 1'b1;
            2: bus.irq_req  = 1'b1;
            default: bus.reti_req = 1'b1;
        endcase
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            wr = wr | lifo_wr_en;
            rd = rd | lifo_rd_en;
            if (bus.ack) begin
                cyc = i;
                e   = bus.err;
                ra  = bus.ret_addr;
                din = lifo_din;
                break;
            end
        end
        drop_reqs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_rst();
        total++;
        if ({busy, bus.ack, bus.err, lifo_wr_en, lifo_rd_en} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {busy, bus.ack, bus.err, lifo_wr_en, lifo_rd_en});
        end
        total++;
        if ({overflow, underflow, in_isr, depth} !== 8'd0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0", {overflow, underflow, in_isr, depth});
        end
        total++;
        if ({bus.ret_addr, lifo_din} !== 22'd0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {bus.ret_addr, lifo_din});
        end
    endtask

    task automatic test_single_push();
        int c; logic e, wr, rd; logic [10:0] ra, din;
        apply_rst();
        do_op(0, 11'h123, 8, c, e, wr, rd, ra, din);
        total++;
        if (c !== 1 || e !== 1'b0 || wr !== 1'b1 || rd !== 1'b0) begin
            bad++;
            $display("FAIL push_lat got=%0d/%b%b%b want=1/010", c, e, wr, rd);
        end
        total++;
        if (din !== 11'h123 || depth !== 5'd1) begin
            bad++;
            $display("FAIL push_data got=%h/%0d want=123/1", din, depth);
        end
    endtask

    task automatic test_lifo_order();
        int c; logic e, wr, rd; logic [10:0] ra, din;
        logic [10:0] pcs [3];
        pcs[0] = 11'h0A1; pcs[1] = 11'h0B2; pcs[2] = 11'h0C3;
        apply_rst();
        for (int i = 0; i < 3; i++)
            do_op(0, pcs[i], 8, c, e, wr, rd, ra, din);
        for (int i = 2; i >= 0; i--) begin
            do_op(1, 11'h000, 8, c, e, wr, rd, ra, din);
            total++;
            if (c !== 2 || e !== 1'b0 || rd !== 1'b1 || wr !== 1'b0 || ra !== pcs[i]) begin
                bad++;
                $display("FAIL pop_%0d got=%0d/%b%b%b/%h want=2/010/%h",
                         i, c, e, wr, rd, ra, pcs[i]);
            end
        end
        total++;
        if (depth !== 5'd0 || bus.ret_addr !== 11'h0A1) begin
            bad++;
            $display("FAIL pop_final got=%0d/%h want=0/0a1", depth, bus.ret_addr);
        end
    endtask

    task automatic test_overflow();
        int c; logic e, wr, rd; logic [10:0] ra, din;
        int good = 0;
        apply_rst();
        for (int i = 0; i < 15; i++) begin
            do_op(0, 11'(16 + i), 8, c, e, wr, rd, ra, din);
            if (c == 1 && !e && wr) good++;
        end
        total++;
        if (good !== 15 || depth !== 5'd15 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fill got=%0d/%0d/%b want=15/15/0", good, depth, overflow);
        end
        do_op(0, 11'h3FF, 8, c, e, wr, rd, ra, din);
        total++;
        if (c !== 1 || e !== 1'b1 || wr !== 1'b0) begin
            bad++;
            $display("FAIL ovf_rej got=%0d/%b%b want=1/10", c, e, wr);
        end
        total++;
        if (overflow !== 1'b1 || depth !== 5'd15 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_flag got=%b/%0d/%b want=1/15/0", overflow, depth, underflow);
        end
        bus.err_clr = 1'b1;
        do_op(0, 11'h3FE, 8, c, e, wr, rd, ra, din);
        total++;
        if (overflow !== 1'b1 || e !== 1'b1) begin
            bad++;
            $display("FAIL set_wins got=%b/%b want=1/1", overflow, e);
        end
        bus.err_clr = 1'b0;
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        total++;
        if (overflow !== 1'b0 || depth !== 5'd15) begin
            bad++;
            $display("FAIL err_clr got=%b/%0d want=0/15", overflow, depth);
        end
    endtask

    task automatic test_underflow();
        int c; logic e, wr, rd; logic [10:0] ra, din;
        apply_rst();
        do_op(0, 11'h055, 8, c, e, wr, rd, ra, din);
        do_op(1, 11'h000, 8, c, e, wr, rd, ra, din);
        do_op(1, 11'h000, 8, c, e, wr, rd, ra, din);
        total++;
        if (c !== 1 || e !== 1'b1 || rd !== 1'b0) begin
            bad++;
            $display("FAIL udf_rej got=%0d/%b%b want=1/10", c, e, rd);
        end
        total++;
        if (underflow !== 1'b1 || depth !== 5'd0 || bus.ret_addr !== 11'h055) begin
            bad++;
            $display("FAIL udf_flag got=%b/%0d/%h want=1/0/055",
                     underflow, depth, bus.ret_addr);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int dbl = 0;
        logic prev = 1'b0;
        apply_rst();
        bus.pc_in    = 11'h111;
        bus.call_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ack) acks++;
            if (bus.ack && prev) dbl++;
            prev = bus.ack;
        end
        bus.call_req = 1'b0;
        @(negedge clk);
        total++;
        if (acks !== 3 || dbl !== 0 || depth !== 5'd3) begin
            bad++;
            $display("FAIL b2b got=%0d/%0d/%0d want=3/0/3", acks, dbl, depth);
        end
    endtask

    task automatic test_irq();
        int c; logic e, wr, rd; logic [10:0] ra, din;
        apply_rst();
        do_op(3, 11'h000, 6, c, e, wr, rd, ra, din);
        total++;
        if (c !== 0 || rd !== 1'b0 || in_isr !== 1'b0) begin
            bad++;
            $display("FAIL reti_idle got=%0d/%b/%b want=0/0/0", c, rd, in_isr);
        end
`ifdef STACK_CTRL_IRQ_EN
        bus.pc_in    = 11'h200;
        bus.irq_req  = 1'b1;
        bus.call_req = 1'b1;
        c = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.ack) begin c = i; din = lifo_din; break; end
        end
        drop_reqs();
        @(negedge clk);
        total++;
        if (c !== 1 || din !== 11'h200 || in_isr !== 1'b1 || depth !== 5'd1) begin
            bad++;
            $display("FAIL irq_first got=%0d/%h/%b/%0d want=1/200/1/1",
                     c, din, in_isr, depth);
        end
        do_op(2, 11'h222, 6, c, e, wr, rd, ra, din);
        total++;
        if (c !== 0 || wr !== 1'b0 || depth !== 5'd1 || in_isr !== 1'b1) begin
            bad++;
            $display("FAIL irq_nest got=%0d/%b/%0d/%b want=0/0/1/1",
                     c, wr, depth, in_isr);
        end
        bus.pc_in    = 11'h300;
        bus.reti_req = 1'b1;
        bus.call_req = 1'b1;
        c = 0; ra = 11'd0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.ack) begin c = i; ra = bus.ret_addr; break; end
        end
        bus.reti_req = 1'b0;
        wr = 1'b0; din = 11'd0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.ack) begin wr = lifo_wr_en; din = lifo_din; break; end
        end
        bus.call_req = 1'b0;
        @(negedge clk);
        total++;
        if (c !== 2 || ra !== 11'h200 || in_isr !== 1'b0) begin
            bad++;
            $display("FAIL reti got=%0d/%h/%b want=2/200/0", c, ra, in_isr);
        end
        total++;
        if (wr !== 1'b1 || din !== 11'h300 || depth !== 5'd1) begin
            bad++;
            $display("FAIL call_after got=%b/%h/%0d want=1/300/1", wr, din, depth);
        end
`else
        do_op(2, 11'h200, 6, c, e, wr, rd, ra, din);
        total++;
        if (c !== 0 || wr !== 1'b0 || in_isr !== 1'b0 || depth !== 5'd0) begin
            bad++;
            $display("FAIL irq_off got=%0d/%b/%b/%0d want=0/0/0/0",
                     c, wr, in_isr, depth);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        int c; logic e, wr, rd; logic [10:0] ra, din;
        int acks = 0;
        logic saw_rd;
        apply_rst();
        do_op(0, 11'h077, 8, c, e, wr, rd, ra, din);
        bus.ret_req = 1'b1;
        @(negedge clk);
        saw_rd = lifo_rd_en;
        rst = 1'b1;
        bus.ret_req = 1'b0;
        @(negedge clk);
        if (bus.ack) acks++;
        rst = 1'b0;
        total++;
        if (saw_rd !== 1'b1 || busy !== 1'b0 || depth !== 5'd0) begin
            bad++;
            $display("FAIL rst_pop got=%b/%b/%0d want=1/0/0", saw_rd, busy, depth);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.ack) acks++;
        end
        total++;
        if (acks !== 0 || busy !== 1'b0 || bus.ret_addr !== 11'd0) begin
            bad++;
            $display("FAIL rst_noack got=%0d/%b/%h want=0/0/0", acks, busy, bus.ret_addr);
        end
    endtask

    initial begin
        drop_reqs();
        bus.err_clr = 1'b0;
        bus.pc_in   = 11'd0;
        test_reset();
        test_single_push();
        test_lifo_order();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_irq();
        test_reset_mid_op();
        total++;
        if (both_seen !== 1'b0) begin
            bad++;
            $display("FAIL wr_rd_excl got=%b want=0", both_seen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
